// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: merges ID/EX/MEM hazards into the stage stall vector,
// issues flushes, runs a stall watchdog; optional perf counters under STALL_PERF_EN.
module pipe_ctrl #(
  parameter int MEM_WAIT      = 2,
  parameter int STALL_TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        mem_req,
  input  logic        flush_req,
  input  logic [31:0] flush_pc,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_err,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count
);

  localparam logic [5:0] ENC_NONE = 6'b000000;
  localparam logic [5:0] ENC_ID   = 6'b000111;
  localparam logic [5:0] ENC_EX   = 6'b001111;
  localparam logic [5:0] ENC_MEM  = 6'b011111;
  localparam logic [7:0] WAIT_LOAD = (MEM_WAIT > 0) ? 8'(MEM_WAIT - 1) : 8'd0;
  localparam logic       MEM_WAIT_ON = (MEM_WAIT > 0);
  localparam logic       WDOG_ON     = (STALL_TIMEOUT > 0);
  localparam logic [31:0] WDOG_LIMIT = 32'(STALL_TIMEOUT);

  typedef enum logic {RUN, MEMWAIT} state_t;

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt, wait_nxt;
  logic [5:0]  hz_enc;
  logic [31:0] stall_run, run_nxt;

  always_comb begin
    hz_enc = ENC_NONE;
    if (stallreq_ex)      hz_enc = ENC_EX;
    else if (stallreq_id) hz_enc = ENC_ID;
  end

  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    stall     = ENC_NONE;
    flush     = 1'b0;
    new_pc    = 32'h0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (flush_req) begin
            flush  = 1'b1;
            new_pc = flush_pc;
          end else if (mem_req && MEM_WAIT_ON) begin
            stall     = ENC_MEM;
            wait_nxt  = WAIT_LOAD;
            state_nxt = MEMWAIT;
          end else begin
            stall = hz_enc;
          end
        end
        MEMWAIT: begin
          if (flush_req) begin
            flush     = 1'b1;
            new_pc    = flush_pc;
            wait_nxt  = 8'd0;
            state_nxt = RUN;
          end else if (wait_cnt != 8'd0) begin
            stall    = ENC_MEM;
            wait_nxt = wait_cnt - 8'd1;
          end else begin
            // release cycle: the access completes, mem_req still belongs to it
            stall     = hz_enc;
            state_nxt = RUN;
          end
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    run_nxt = stall_run;
    if (stall == ENC_NONE || flush) run_nxt = 32'h0;
    else if (stall_run != 32'hFFFF_FFFF) run_nxt = stall_run + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      stall_run <= 32'h0;
      stall_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_nxt;
      stall_run <= run_nxt;
      if (WDOG_ON && run_nxt == WDOG_LIMIT) stall_err <= 1'b1;
    end
  end

`ifdef STALL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= 32'h0;
      flush_count  <= 32'h0;
    end else begin
      if (stall != ENC_NONE && stall_cycles != 32'hFFFF_FFFF) stall_cycles <= stall_cycles + 32'd1;
      if (flush && flush_count != 32'hFFFF_FFFF) flush_count <= flush_count + 32'd1;
    end
  end
`else
  assign stall_cycles = 32'h0;
  assign flush_count  = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios followed by random stimulus,
// all compared against a cycle budget model of the stall/flush rules.
module tb_pipe_ctrl;
  localparam int MW = 2;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst, stallreq_id, stallreq_ex, mem_req, flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic        flush, stall_err;
  logic [31:0] new_pc, stall_cycles, flush_count;

  int total = 0;
  int bad   = 0;

  // model state
  int          m_left = 0;
  bit          m_rel  = 0;
  int          m_run  = 0;
  bit          m_err  = 0;
  logic [31:0] m_sc = 0, m_fc = 0;

  pipe_ctrl #(.MEM_WAIT(MW), .STALL_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
    .mem_req(mem_req), .flush_req(flush_req), .flush_pc(flush_pc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_err(stall_err),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit id, input bit ex, input bit mr,
                      input bit fr, input logic [31:0] pc);
    logic [5:0]  e_stall, hz;
    logic        e_flush;
    logic [31:0] e_pc;
    int          start_mem;
    @(negedge clk);
    rst = r; stallreq_id = id; stallreq_ex = ex; mem_req = mr; flush_req = fr; flush_pc = pc;
    #1;
    hz = ex ? 6'b001111 : (id ? 6'b000111 : 6'b000000);
    e_stall = 6'b0; e_flush = 1'b0; e_pc = 32'h0; start_mem = 0;
    if (r) begin
    end else if (fr) begin
      e_flush = 1'b1; e_pc = pc;
    end else if (m_left > 0) begin
      e_stall = 6'b011111;
    end else if (m_rel) begin
      e_stall = hz;
    end else if (mr && MW > 0) begin
      e_stall = 6'b011111; start_mem = 1;
    end else begin
      e_stall = hz;
    end
    chk("stall", 32'(stall), 32'(e_stall));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("new_pc", new_pc, e_pc);
    chk("stall_err", 32'(stall_err), 32'(m_err));
`ifdef STALL_PERF_EN
    chk("stall_cycles", stall_cycles, m_sc);
    chk("flush_count", flush_count, m_fc);
`else
    chk("stall_cycles_off", stall_cycles, 32'h0);
    chk("flush_count_off", flush_count, 32'h0);
`endif
    if (r) begin
      m_left = 0; m_rel = 0; m_run = 0; m_err = 0; m_sc = 0; m_fc = 0;
    end else begin
      if (fr) begin
        m_left = 0; m_rel = 0;
      end else if (m_left > 0) begin
        m_left--; if (m_left == 0) m_rel = 1;
      end else if (m_rel) begin
        m_rel = 0;
      end else if (start_mem != 0) begin
        m_left = MW - 1; m_rel = (m_left == 0);
      end
      if (e_stall != 6'b0 && !e_flush) m_run++; else m_run = 0;
      if (TO > 0 && m_run >= TO) m_err = 1;
      if (e_stall != 6'b0) m_sc++;
      if (e_flush) m_fc++;
    end
  endtask

  initial begin
    rst = 1'b1; stallreq_id = 0; stallreq_ex = 0; mem_req = 0; flush_req = 0; flush_pc = 0;
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("reset_stall", 32'(stall), 32'h0);

    // MEM access: two wait cycles then a release cycle
    step(0, 0, 0, 1, 0, 0);
    chk("mem_c0", 32'(stall), 32'h1F);
    step(0, 0, 0, 1, 0, 0);
    chk("mem_c1", 32'(stall), 32'h1F);
    step(0, 0, 0, 1, 0, 0);
    chk("mem_c2", 32'(stall), 32'h00);

    step(0, 1, 1, 0, 0, 0);
    chk("id_ex", 32'(stall), 32'h0F);
    step(0, 1, 0, 0, 0, 0);
    chk("id_only", 32'(stall), 32'h07);

    // flush aborts a pending access
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 1, 32'h100);
    chk("fl_flush", 32'(flush), 32'h1);
    chk("fl_pc", new_pc, 32'h100);
    chk("fl_stall", 32'(stall), 32'h0);
    step(0, 0, 0, 0, 0, 0);
    chk("fl_run", 32'(stall), 32'h0);
`ifdef STALL_PERF_EN
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 32'h40);
    step(0, 0, 0, 0, 0, 0);
    chk("perf_sc", stall_cycles, 32'd2);
    chk("perf_fc", flush_count, 32'd1);
`endif

    // watchdog
    step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("wd_set", 32'(stall_err), 32'h1);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("wd_sticky", 32'(stall_err), 32'h1);

    // reset in the middle of a wait
    step(0, 0, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("rst_mid_stall", 32'(stall), 32'h0);
    chk("rst_mid_err", 32'(stall_err), 32'h0);
    chk("rst_mid_sc", stall_cycles, 32'h0);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(63) == 0), $urandom_range(1), ($urandom_range(3) == 0),
           ($urandom_range(2) == 0), ($urandom_range(9) == 0), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
